// File: rtl/alu_pipe_param_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_param_if
// Handshake bundle between an operand-issue unit (master) and the pipelined
// ALU (slave), including the result/writeback side.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   TAG_W  sideband tag width in bits (>= 1)
//
// Signals:
//   in_valid / in_ready          operation handshake
//   in_op[2:0], in_a, in_b       opcode and operands
//   in_cin                       carry-in (ADD) / borrow-in (SUB)
//   in_tag                       opaque sideband tag
//   out_valid / out_ready        result handshake
//   out_result, out_flags[4:0]   result and {V,N,Z,C,P}
//   out_tag                      tag of the delivered result
// -----------------------------------------------------------------------------
interface alu_pipe_param_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [4:0]       out_flags;
   logic [TAG_W-1:0] out_tag;

   // Issue/writeback side: drives operations, consumes results
   modport master (
      output in_valid, in_op, in_a, in_b, in_cin, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_flags, out_tag
   );

   // ALU side: accepts operations, produces results
   modport slave (
      input  in_valid, in_op, in_a, in_b, in_cin, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_flags, out_tag
   );
endinterface

// File: rtl/alu_pipe_param.sv
// -----------------------------------------------------------------------------
// alu_pipe_param
// Parametrised two-stage pipelined ALU with valid/ready flow control and an
// opaque tag sideband.
//
//   Stage 1 captures opcode, operands, carry-in and tag.
//   Stage 2 computes result and flags from the stage-1 registers and holds
//   them in the output registers until the consumer takes them.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    alu_pipe_param_if.slave (operation and result handshakes)
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASSA, 6 NAND/ADDS, 7 CMP.
// Flags:   {V,N,Z,C,P} = overflow, negative, zero, carry/borrow, odd parity.
//
// Build option:
//   ALU_SAT_EN  when defined, opcode 6 is a signed saturating add (ADDS);
//               otherwise opcode 6 is NAND and no saturation logic exists.
// -----------------------------------------------------------------------------
module alu_pipe_param #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input logic              clk,
   input logic              rst_n,
   alu_pipe_param_if.slave  bus
);

   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_PASSA = 3'd5;
   localparam logic [2:0] OP_OP6   = 3'd6;
   localparam logic [2:0] OP_CMP   = 3'd7;

   // Odd parity of a result word
   function automatic logic parity_f(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // Signed overflow from an unsigned (WIDTH+1)-bit add/sub: the carry (or
   // borrow) into the MSB differs from the carry (or borrow) out of it.
   function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                  input logic [WIDTH:0] r);
      return (a_msb ^ b_msb ^ r[WIDTH-1]) ^ r[WIDTH];
   endfunction

   // ---------------------------------------------------------------- state
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_op_q,    s1_op_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic             s1_cin_q,   s1_cin_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   logic             out_valid_q,  out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic [4:0]       out_flags_q,  out_flags_d;
   logic [TAG_W-1:0] out_tag_q,    out_tag_d;

   // ---------------------------------------------------------- handshakes
   logic s1_adv_s;
   logic in_ready_s;
   logic accept_s;

   // Stage 1 may move on whenever the output register is empty or draining;
   // this also lets a full stage 1 accept a new operation in the same cycle.
   assign s1_adv_s   = !out_valid_q || bus.out_ready;
   assign in_ready_s = !s1_valid_q || s1_adv_s;
   assign accept_s   = bus.in_valid && in_ready_s;

   // ------------------------------------------------------------ ALU core
   logic [WIDTH:0]   add_u_s;
   logic [WIDTH:0]   sub_u_s;
   logic [WIDTH:0]   cmp_u_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] flag_val_s;
   logic             alu_v_s;
   logic             alu_c_s;
   logic [4:0]       alu_flags_s;
`ifdef ALU_SAT_EN
   logic [WIDTH:0]   sat_u_s;
   logic             sat_ovf_s;
   logic [WIDTH-1:0] sat_res_s;
`endif

   // Unsigned WIDTH+1 bit arithmetic; the top bit is carry-out / borrow-out
   assign add_u_s = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
   assign sub_u_s = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{WIDTH{1'b0}}, s1_cin_q};
   assign cmp_u_s = {1'b0, s1_a_q} - {1'b0, s1_b_q};

`ifdef ALU_SAT_EN
   // Saturating add: on overflow both operands share a sign, so a's MSB
   // tells which rail to clamp to.
   always_comb begin
      sat_u_s   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      sat_ovf_s = ovf_f(s1_a_q[MSB], s1_b_q[MSB], sat_u_s);
      if (!sat_ovf_s) begin
         sat_res_s = sat_u_s[MSB:0];
      end else if (s1_a_q[MSB]) begin
         sat_res_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         sat_res_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`endif

   // Result, carry and overflow selection; flag_val_s is what N/Z look at
   always_comb begin
      alu_res_s  = s1_a_q;
      flag_val_s = s1_a_q;
      alu_v_s    = 1'b0;
      alu_c_s    = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            alu_res_s  = add_u_s[MSB:0];
            flag_val_s = add_u_s[MSB:0];
            alu_c_s    = add_u_s[WIDTH];
            alu_v_s    = ovf_f(s1_a_q[MSB], s1_b_q[MSB], add_u_s);
         end
         OP_SUB: begin
            alu_res_s  = sub_u_s[MSB:0];
            flag_val_s = sub_u_s[MSB:0];
            alu_c_s    = sub_u_s[WIDTH];
            alu_v_s    = ovf_f(s1_a_q[MSB], s1_b_q[MSB], sub_u_s);
         end
         OP_AND: begin
            alu_res_s  = s1_a_q & s1_b_q;
            flag_val_s = s1_a_q & s1_b_q;
         end
         OP_OR: begin
            alu_res_s  = s1_a_q | s1_b_q;
            flag_val_s = s1_a_q | s1_b_q;
         end
         OP_XOR: begin
            alu_res_s  = s1_a_q ^ s1_b_q;
            flag_val_s = s1_a_q ^ s1_b_q;
         end
         OP_PASSA: begin
            alu_res_s  = s1_a_q;
            flag_val_s = s1_a_q;
         end
         OP_OP6: begin
`ifdef ALU_SAT_EN
            alu_res_s  = sat_res_s;
            flag_val_s = sat_res_s;
            alu_c_s    = sat_u_s[WIDTH];
            alu_v_s    = sat_ovf_s;
`else
            alu_res_s  = ~(s1_a_q & s1_b_q);
            flag_val_s = ~(s1_a_q & s1_b_q);
`endif
         end
         OP_CMP: begin
            // Result is a unchanged; flags describe a-b without borrow-in
            alu_res_s  = s1_a_q;
            flag_val_s = cmp_u_s[MSB:0];
            alu_c_s    = cmp_u_s[WIDTH];
            alu_v_s    = ovf_f(s1_a_q[MSB], s1_b_q[MSB], cmp_u_s);
         end
         default: begin
            alu_res_s  = s1_a_q;
            flag_val_s = s1_a_q;
         end
      endcase
      alu_flags_s = {alu_v_s, flag_val_s[MSB], (flag_val_s == {WIDTH{1'b0}}),
                     alu_c_s, parity_f(alu_res_s)};
   end

   // ------------------------------------------------------ next state
   // Stage 1: capture on accept, empty when it drains, otherwise hold.
   // Operand inputs are only sampled on accept so idle garbage never enters.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_cin_d   = s1_cin_q;
      s1_tag_d   = s1_tag_q;
      if (accept_s) begin
         s1_valid_d = 1'b1;
         s1_op_d    = bus.in_op;
         s1_a_d     = bus.in_a;
         s1_b_d     = bus.in_b;
         s1_cin_d   = bus.in_cin;
         s1_tag_d   = bus.in_tag;
      end else if (s1_adv_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage 2: load computed result when stage 1 advances with a valid op;
   // while stalled every output register holds.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_flags_d  = out_flags_q;
      out_tag_d    = out_tag_q;
      if (s1_adv_s) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_result_d = alu_res_s;
            out_flags_d  = alu_flags_s;
            out_tag_d    = s1_tag_q;
         end else begin
            out_result_d = out_result_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // ------------------------------------------------------ registers
   // All pipeline state, cleared by synchronous reset (in-flight ops dropped)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= 3'd0;
         s1_a_q       <= {WIDTH{1'b0}};
         s1_b_q       <= {WIDTH{1'b0}};
         s1_cin_q     <= 1'b0;
         s1_tag_q     <= {TAG_W{1'b0}};
         out_valid_q  <= 1'b0;
         out_result_q <= {WIDTH{1'b0}};
         out_flags_q  <= 5'd0;
         out_tag_q    <= {TAG_W{1'b0}};
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_cin_q     <= s1_cin_d;
         s1_tag_q     <= s1_tag_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_flags_q  <= out_flags_d;
         out_tag_q    <= out_tag_d;
      end
   end

   // ------------------------------------------------------ outputs
   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_flags  = out_flags_q;
   assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_param
// Self-checking bench for alu_pipe_param at WIDTH=8, TAG_W=4. A reference
// model computes results from integer arithmetic; a scoreboard queue holds
// expected results in issue order and is checked on every output transfer.
// Inputs change 2 time units after a rising edge; everything is sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_pipe_param;

   localparam int W    = 8;
   localparam int T    = 4;
   localparam int FULL = 256;
   localparam int HALF = 128;

   logic clk;
   logic rst_n;

   alu_pipe_param_if #(.WIDTH(W), .TAG_W(T)) bus ();

   alu_pipe_param #(.WIDTH(W), .TAG_W(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: {result[7:0], V, N, Z, C, P} from plain integer arithmetic
   function automatic logic [12:0] model(input int op, input int a, input int b, input int cin);
      int sa, sb, full, sres, res, fv;
      logic v, c;
      logic [7:0] r8, f8;
      sa = (a >= HALF) ? a - FULL : a;
      sb = (b >= HALF) ? b - FULL : b;
      v = 1'b0; c = 1'b0; res = a; fv = a; full = 0; sres = 0;
      case (op)
         0: begin
            full = a + b + cin; res = full % FULL; c = (full >= FULL);
            sres = sa + sb + cin; v = (sres >= HALF) || (sres < -HALF); fv = res;
         end
         1: begin
            full = a - b - cin; res = (full + FULL) % FULL; c = (full < 0);
            sres = sa - sb - cin; v = (sres >= HALF) || (sres < -HALF); fv = res;
         end
         2: begin res = a & b; fv = res; end
         3: begin res = a | b; fv = res; end
         4: begin res = a ^ b; fv = res; end
         5: begin res = a; fv = res; end
         6: begin
`ifdef ALU_SAT_EN
            sres = sa + sb; c = ((a + b) >= FULL);
            if (sres >= HALF) begin res = HALF - 1; v = 1'b1; end
            else if (sres < -HALF) begin res = HALF; v = 1'b1; end
            else res = (sres + FULL) % FULL;
`else
            res = (~(a & b)) & (FULL - 1);
`endif
            fv = res;
         end
         7: begin
            full = a - b; fv = (full + FULL) % FULL; res = a; c = (full < 0);
            sres = sa - sb; v = (sres >= HALF) || (sres < -HALF);
         end
         default: begin res = a; fv = a; end
      endcase
      r8 = res[7:0];
      f8 = fv[7:0];
      return {r8, v, f8[7], (f8 == 8'h00), c, ^r8};
   endfunction

   // Scoreboard and per-cycle compare process
   logic [16:0] exp_q[$];           // {tag, result, flags}
   logic        stall_prev = 1'b0;
   logic        rst_prev   = 1'b0;
   logic [16:0] snap_prev  = 17'd0;
   logic        vld_prev   = 1'b0;

   always @(negedge clk) begin
      logic [16:0] e;
      if (stall_prev && rst_prev && rst_n) begin
         chk("stall_stable", {bus.out_valid, bus.out_tag, bus.out_result, bus.out_flags},
             {vld_prev, snap_prev});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      rst_prev   = rst_n;
      vld_prev   = bus.out_valid;
      snap_prev  = {bus.out_tag, bus.out_result, bus.out_flags};
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_result", {bus.out_tag, bus.out_result, bus.out_flags}, e);
            end
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            exp_q.push_back({bus.in_tag, model(bus.in_op, bus.in_a, bus.in_b, bus.in_cin)});
         end
      end
   end

   // Present one op and hold it until accepted; returns cycles spent
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [3:0] tag, output int n);
      logic acc;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.in_cin = cin; bus.in_tag = tag;
      n = 0;
      do begin
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #2;
         n++;
      end while (!acc && n < 100);
      chk("issue_accepted", acc, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   // Single op into an empty pipe: check latency and literal result
   task automatic directed(input string nm, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin, input logic [3:0] tag,
                           input logic [7:0] er, input logic [4:0] ef);
      @(posedge clk); #2;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.in_cin = cin; bus.in_tag = tag;
      @(negedge clk); chk({nm, "_in_ready"}, bus.in_ready, 1'b1);
      @(posedge clk); #2; bus.in_valid = 1'b0;
      @(negedge clk); chk({nm, "_not_early"}, bus.out_valid, 1'b0);
      @(negedge clk);
      chk({nm, "_valid"},  bus.out_valid,  1'b1);
      chk({nm, "_result"}, bus.out_result, er);
      chk({nm, "_flags"},  bus.out_flags,  ef);
      chk({nm, "_tag"},    bus.out_tag,    tag);
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == 0 && bus.out_valid !== 1'b1) break;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int start;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = 8'h00; bus.in_b = 8'h00;
      bus.in_cin = 1'b0; bus.in_tag = 4'h0; bus.out_ready = 1'b1;

      // Pin the model against hand-computed values
      chk("model_add", model(0, 8'hFF, 8'h01, 0), {8'h00, 5'b00110});
      chk("model_sub", model(1, 8'h80, 8'h01, 0), {8'h7F, 5'b10001});
      chk("model_cmp", model(7, 8'h05, 8'h09, 0), {8'h05, 5'b01010});
      chk("model_subb", model(1, 8'h00, 8'h7F, 1), {8'h80, 5'b01011});

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_result", bus.out_result, 8'h00);
      chk("rst_flags", bus.out_flags, 5'd0);
      chk("rst_tag", bus.out_tag, 4'h0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #2; rst_n = 1'b1;

      directed("add", 3'd0, 8'hFF, 8'h01, 1'b0, 4'hA, 8'h00, 5'b00110);
      directed("sub", 3'd1, 8'h80, 8'h01, 1'b0, 4'h6, 8'h7F, 5'b10001);
      directed("cmp", 3'd7, 8'h05, 8'h09, 1'b0, 4'h7, 8'h05, 5'b01010);
`ifdef ALU_SAT_EN
      directed("adds", 3'd6, 8'h70, 8'h20, 1'b0, 4'h8, 8'h7F, 5'b10001);
`else
      directed("nand", 3'd6, 8'h70, 8'h20, 1'b0, 4'h8, 8'hDF, 5'b01001);
`endif
      drain();

      // Backpressure: three ops with out_ready low
      @(posedge clk); #2; bus.out_ready = 1'b0;
      issue(3'd0, 8'h01, 8'h02, 1'b0, 4'h1, n);
      issue(3'd2, 8'hF0, 8'h3C, 1'b0, 4'h2, n);
      bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_a = 8'hAA; bus.in_b = 8'h0F;
      bus.in_cin = 1'b0; bus.in_tag = 4'h3;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", bus.in_ready, 1'b0);
         chk("bp_hold_valid", bus.out_valid, 1'b1);
         chk("bp_hold_tag", bus.out_tag, 4'h1);
      end
      @(posedge clk); #2; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_back", bus.in_ready, 1'b1);
      chk("bp_tag1", {bus.out_valid, bus.out_tag}, {1'b1, 4'h1});
      @(posedge clk); #2; bus.in_valid = 1'b0;
      @(negedge clk); chk("bp_tag2", {bus.out_valid, bus.out_tag}, {1'b1, 4'h2});
      @(negedge clk); chk("bp_tag3", {bus.out_valid, bus.out_tag}, {1'b1, 4'h3});
      drain();

      // Streaming: 16 back-to-back random ops, one result per cycle
      start = xfer_cnt;
      for (int i = 0; i < 16; i++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4'(i), n);
         chk("stream_no_stall", n, 1);
      end
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("stream_count", xfer_cnt - start, 16);
      drain();

      // Reset with two ops in flight
      @(posedge clk); #2; bus.out_ready = 1'b0;
      issue(3'd0, 8'h11, 8'h22, 1'b1, 4'h4, n);
      issue(3'd1, 8'h33, 8'h44, 1'b0, 4'h5, n);
      rst_n = 1'b0;
      @(posedge clk); #2; rst_n = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      chk("mid_rst_zero", {bus.out_tag, bus.out_result, bus.out_flags}, 17'd0);
      chk("mid_rst_in_ready", bus.in_ready, 1'b1);
      directed("post_rst", 3'd3, 8'h50, 8'h05, 1'b0, 4'h9, 8'h55, 5'b00000);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
